// File: rtl/matmul_pkg.sv
// Shared types and default configuration for the matrix-multiply sequencing controller.
// The state encoding here is visible to software through current_state.
package matmul_pkg;

  localparam int unsigned MaxDimDef        = 8;
  localparam int unsigned DimWDef          = 4;
  localparam int unsigned AddrWDef         = 6;
  localparam int unsigned ResBytesDef      = 2;
  localparam logic [7:0]  StartByteDef     = 8'hA5;
  localparam int unsigned TimeoutCyclesDef = 65535;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StHdr0    = 3'd1,
    StHdr1    = 3'd2,
    StLoadA   = 3'd3,
    StLoadB   = 3'd4,
    StCompute = 3'd5,
    StSend    = 3'd6,
    StErr     = 3'd7
  } state_e;

  function automatic logic dim_ok(input int unsigned d, input int unsigned max_dim);
    return (d >= 32'd1) && (d <= max_dim);
  endfunction

endpackage

// File: rtl/matmul_elem_counter.sv
// Loadable up-counter with a terminal-count flag, used for element and result addressing.
// Load has priority over increment.
module matmul_elem_counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Frame sequencer for a UART-fed matrix multiplier: header, A/B load, compute, result send.
// Define MATMUL_CTRL_TIMEOUT_EN to abort COMPUTE into ERR after TIMEOUT_CYCLES.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned MAX_DIM        = MaxDimDef,
  parameter int unsigned DIM_W          = DimWDef,
  parameter int unsigned ADDR_W         = AddrWDef,
  parameter int unsigned RES_BYTES      = ResBytesDef,
  parameter logic [7:0]  START_BYTE     = StartByteDef,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef,
  localparam int unsigned BSW = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  input  logic              mult_done,
  output logic              rx_enable,
  output logic              tx_start,
  output logic              mult_start,
  output logic [2:0]        current_state,
  output logic [DIM_W-1:0]  dim_m,
  output logic [DIM_W-1:0]  dim_k,
  output logic [DIM_W-1:0]  dim_p,
  output logic              wr_en_a,
  output logic              wr_en_b,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] res_addr,
  output logic [BSW-1:0]    res_byte_sel,
  output logic              error
);

  localparam int unsigned PW = 2 * DIM_W;

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_p_q, dim_p_d;
  logic [BSW-1:0]     byte_sel_q, byte_sel_d;
  logic               tx_start_q, tx_start_d;
  logic               mult_start_q, mult_start_d;
  logic               error_q, error_d;
  logic [PW-1:0]      prod_mk, prod_kp, prod_mp;
  logic [ADDR_W-1:0]  elem_cnt, elem_term, res_cnt, res_term;
  logic               elem_load, elem_inc, elem_tc;
  logic               res_load, res_inc, res_tc;

  // Products kept at full 2*DIM_W width before forming terminal counts.
  assign prod_mk   = PW'(dim_m_q) * PW'(dim_k_q);
  assign prod_kp   = PW'(dim_k_q) * PW'(dim_p_q);
  assign prod_mp   = PW'(dim_m_q) * PW'(dim_p_q);
  assign elem_term = (state_q == StLoadB) ? ADDR_W'(prod_kp - PW'(1)) : ADDR_W'(prod_mk - PW'(1));
  assign res_term  = ADDR_W'(prod_mp - PW'(1));

`ifdef MATMUL_CTRL_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  assign to_cnt_d = (state_q == StCompute) ? to_cnt_q + 32'd1 : '0;
  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    dim_m_d    = dim_m_q;
    dim_k_d    = dim_k_q;
    dim_p_d    = dim_p_q;
    byte_sel_d = byte_sel_q;
    error_d    = error_q;
    elem_load  = 1'b0;
    elem_inc   = 1'b0;
    res_load   = 1'b0;
    res_inc    = 1'b0;
    wr_en_a    = 1'b0;
    wr_en_b    = 1'b0;
    // Registered pulse: one cycle after busy is seen low, never on adjacent cycles.
    tx_start_d = (state_q == StSend) && !tx_busy && !tx_start_q;
    unique case (state_q)
      StIdle: begin
        if (rx_valid && (rx_data == START_BYTE)) begin
          state_d = StHdr0;
          error_d = 1'b0;
        end
      end
      StHdr0: begin
        if (rx_valid) begin
          dim_m_d = DIM_W'(rx_data[3:0]);
          dim_k_d = DIM_W'(rx_data[7:4]);
          state_d = StHdr1;
        end
      end
      StHdr1: begin
        if (rx_valid) begin
          dim_p_d   = DIM_W'(rx_data[3:0]);
          elem_load = 1'b1;
          if (dim_ok(32'(dim_m_q), MAX_DIM) && dim_ok(32'(dim_k_q), MAX_DIM) &&
              dim_ok(32'(rx_data[3:0]), MAX_DIM)) begin
            state_d = StLoadA;
          end else begin
            state_d = StErr;
            error_d = 1'b1;
          end
        end
      end
      StLoadA, StLoadB: begin
        wr_en_a = rx_valid && (state_q == StLoadA);
        wr_en_b = rx_valid && (state_q == StLoadB);
        if (rx_valid) begin
          if (elem_tc) begin
            elem_load = 1'b1;
            state_d   = (state_q == StLoadA) ? StLoadB : StCompute;
          end else begin
            elem_inc = 1'b1;
          end
        end
      end
      StCompute: begin
        if (mult_done) begin
          state_d    = StSend;
          res_load   = 1'b1;
          byte_sel_d = '0;
        end
`ifdef MATMUL_CTRL_TIMEOUT_EN
        else if (to_cnt_q == TIMEOUT_CYCLES - 1) begin
          state_d = StErr;
          error_d = 1'b1;
        end
`endif
      end
      StSend: begin
        if (tx_start_q) begin
          if (byte_sel_q == BSW'(RES_BYTES - 1)) begin
            byte_sel_d = '0;
            if (res_tc) state_d = StIdle;
            else        res_inc = 1'b1;
          end else begin
            byte_sel_d = byte_sel_q + BSW'(1);
          end
        end
      end
      StErr: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    mult_start_d = (state_d == StCompute) && (state_q != StCompute);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      dim_m_q      <= '0;
      dim_k_q      <= '0;
      dim_p_q      <= '0;
      byte_sel_q   <= '0;
      tx_start_q   <= 1'b0;
      mult_start_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dim_m_q      <= dim_m_d;
      dim_k_q      <= dim_k_d;
      dim_p_q      <= dim_p_d;
      byte_sel_q   <= byte_sel_d;
      tx_start_q   <= tx_start_d;
      mult_start_q <= mult_start_d;
      error_q      <= error_d;
    end
  end

  matmul_elem_counter #(.W(ADDR_W)) u_elem_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (elem_load),
    .load_val_i ('0),
    .inc_i      (elem_inc),
    .term_i     (elem_term),
    .count_o    (elem_cnt),
    .tc_o       (elem_tc)
  );

  matmul_elem_counter #(.W(ADDR_W)) u_res_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (res_load),
    .load_val_i ('0),
    .inc_i      (res_inc),
    .term_i     (res_term),
    .count_o    (res_cnt),
    .tc_o       (res_tc)
  );

  assign rx_enable     = (state_q != StCompute) && (state_q != StSend) && (state_q != StErr);
  assign tx_start      = tx_start_q;
  assign mult_start    = mult_start_q;
  assign current_state = state_q;
  assign dim_m         = dim_m_q;
  assign dim_k         = dim_k_q;
  assign dim_p         = dim_p_q;
  assign wr_addr       = elem_cnt;
  assign res_addr      = res_cnt;
  assign res_byte_sel  = byte_sel_q;
  assign error         = error_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed self-checking bench for matmul_seq_ctrl (default parameters, TIMEOUT_CYCLES=100).
module tb_matmul_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, rx_valid, tx_busy, mult_done;
  logic [7:0] rx_data;
  logic       rx_enable, tx_start, mult_start, wr_en_a, wr_en_b, error;
  logic [2:0] current_state;
  logic [3:0] dim_m, dim_k, dim_p;
  logic [5:0] wr_addr, res_addr;
  logic [0:0] res_byte_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matmul_seq_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .tx_busy       (tx_busy),
    .mult_done     (mult_done),
    .rx_enable     (rx_enable),
    .tx_start      (tx_start),
    .mult_start    (mult_start),
    .current_state (current_state),
    .dim_m         (dim_m),
    .dim_k         (dim_k),
    .dim_p         (dim_p),
    .wr_en_a       (wr_en_a),
    .wr_en_b       (wr_en_b),
    .wr_addr       (wr_addr),
    .res_addr      (res_addr),
    .res_byte_sel  (res_byte_sel),
    .error         (error)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; mult_done = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick;
    rx_valid = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) send(8'(i));
  endtask

  task automatic test_reset;
    do_reset;
    total++;
    if (current_state !== 3'd0) begin
      bad++; $display("FAIL reset_state: got %0d want 0", current_state);
    end
    total++;
    if ({tx_start, mult_start, wr_en_a, wr_en_b, error, rx_enable} !== 6'b000001) begin
      bad++; $display("FAIL reset_flags: got %b want 000001",
                      {tx_start, mult_start, wr_en_a, wr_en_b, error, rx_enable});
    end
    total++;
    if ({dim_m, dim_k, dim_p, wr_addr, res_addr, res_byte_sel} !== 25'd0) begin
      bad++; $display("FAIL reset_regs: got %h want 0",
                      {dim_m, dim_k, dim_p, wr_addr, res_addr, res_byte_sel});
    end
  endtask

  task automatic test_load;
    int pulses;
    do_reset;
    send(8'hA5);
    total++;
    if (current_state !== 3'd1) begin
      bad++; $display("FAIL load_hdr0: got %0d want 1", current_state);
    end
    send(8'h33);
    total++;
    if ({current_state, dim_m, dim_k} !== {3'd2, 4'd3, 4'd3}) begin
      bad++; $display("FAIL load_hdr1: got %h want %h", {current_state, dim_m, dim_k},
                      {3'd2, 4'd3, 4'd3});
    end
    send(8'h03);
    total++;
    if ({current_state, dim_p} !== {3'd3, 4'd3}) begin
      bad++; $display("FAIL load_enter_a: got %h want %h", {current_state, dim_p}, {3'd3, 4'd3});
    end
    for (int i = 0; i < 9; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i + 16);
      #1;
      total++;
      if ({wr_en_a, wr_en_b, wr_addr} !== {1'b1, 1'b0, 6'(i)}) begin
        bad++; $display("FAIL load_a_wr[%0d]: got %b/%b/%0d want 1/0/%0d", i, wr_en_a, wr_en_b,
                        wr_addr, i);
      end
      tick;
    end
    rx_valid = 1'b0;
    #1;
    total++;
    if ({current_state, wr_en_b, rx_enable} !== {3'd4, 1'b0, 1'b1}) begin
      bad++; $display("FAIL load_enter_b: got %b want 10001", {current_state, wr_en_b, rx_enable});
    end
    tick;
    for (int i = 0; i < 9; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i + 32);
      #1;
      total++;
      if ({wr_en_a, wr_en_b, wr_addr} !== {1'b0, 1'b1, 6'(i)}) begin
        bad++; $display("FAIL load_b_wr[%0d]: got %b/%b/%0d want 0/1/%0d", i, wr_en_a, wr_en_b,
                        wr_addr, i);
      end
      tick;
    end
    rx_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (mult_start) pulses++;
      tick;
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL load_mult_start: got %0d pulses want 1", pulses);
    end
    total++;
    if ({current_state, rx_enable} !== {3'd5, 1'b0}) begin
      bad++; $display("FAIL load_compute: got %b want 1010", {current_state, rx_enable});
    end
  endtask

  task automatic test_send;
    int pulses, adj;
    logic prev, done;
    do_reset;
    send(8'hA5); send(8'h32); send(8'h04);
    feed(6); feed(12);
    tick;
    mult_done = 1'b1; tick; mult_done = 1'b0;
    total++;
    if ({current_state, res_addr, res_byte_sel} !== {3'd6, 6'd0, 1'b0}) begin
      bad++; $display("FAIL send_enter: got %h want %h", {current_state, res_addr, res_byte_sel},
                      {3'd6, 6'd0, 1'b0});
    end
    pulses = 0; adj = 0; prev = 1'b0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (tx_start) begin
        total++;
        if ({res_addr, res_byte_sel} !== {6'(pulses / 2), 1'(pulses % 2)}) begin
          bad++; $display("FAIL send_pulse[%0d]: got addr %0d sel %0d want addr %0d sel %0d",
                          pulses, res_addr, res_byte_sel, pulses / 2, pulses % 2);
        end
        if (prev) adj++;
        pulses++;
      end
      prev = tx_start;
      if (current_state == 3'd0) done = 1'b1;
      else tick;
    end
    total++;
    if (adj != 0) begin
      bad++; $display("FAIL send_adjacent: got %0d adjacent pulses want 0", adj);
    end
    total++;
    if (pulses != 16) begin
      bad++; $display("FAIL send_count: got %0d want 16", pulses);
    end
    total++;
    if (current_state !== 3'd0) begin
      bad++; $display("FAIL send_idle: got %0d want 0", current_state);
    end
  endtask

  task automatic test_error;
    do_reset;
    mult_done = 1'b1; tick; mult_done = 1'b0;
    total++;
    if (current_state !== 3'd0) begin
      bad++; $display("FAIL err_done_ignored: got %0d want 0", current_state);
    end
    send(8'hA5); send(8'h90);
    total++;
    if ({dim_m, dim_k} !== {4'd0, 4'd9}) begin
      bad++; $display("FAIL err_dims: got %h want 09", {dim_m, dim_k});
    end
    send(8'h01);
    total++;
    if ({current_state, error} !== {3'd7, 1'b1}) begin
      bad++; $display("FAIL err_state: got %b want 1111", {current_state, error});
    end
    tick;
    total++;
    if ({current_state, error} !== {3'd0, 1'b1}) begin
      bad++; $display("FAIL err_to_idle: got %b want 0001", {current_state, error});
    end
    send(8'h11);
    total++;
    if ({current_state, error} !== {3'd0, 1'b1}) begin
      bad++; $display("FAIL err_ignore_byte: got %b want 0001", {current_state, error});
    end
    send(8'hA5);
    total++;
    if ({current_state, error} !== {3'd1, 1'b0}) begin
      bad++; $display("FAIL err_clear: got %b want 0010", {current_state, error});
    end
  endtask

  task automatic test_busy;
    int hits;
    do_reset;
    send(8'hA5); send(8'h11); send(8'h01);
    feed(1); feed(1);
    tx_busy = 1'b1;
    mult_done = 1'b1; tick; mult_done = 1'b0;
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      if (tx_start) hits++;
      tick;
    end
    total++;
    if (hits != 0 || current_state !== 3'd6) begin
      bad++; $display("FAIL busy_hold: got %0d pulses state %0d want 0 pulses state 6", hits,
                      current_state);
    end
    tx_busy = 1'b0;
    #1;
    total++;
    if (tx_start !== 1'b0) begin
      bad++; $display("FAIL busy_fall_same: got %b want 0", tx_start);
    end
    tick;
    total++;
    if (tx_start !== 1'b1) begin
      bad++; $display("FAIL busy_first_pulse: got %b want 1", tx_start);
    end
    for (int c = 0; c < 20 && current_state != 3'd0; c++) tick;
    total++;
    if (current_state !== 3'd0) begin
      bad++; $display("FAIL busy_idle: got %0d want 0", current_state);
    end
  endtask

  task automatic test_rst_midload;
    int pulses;
    do_reset;
    send(8'hA5); send(8'h33); send(8'h03);
    feed(4);
    total++;
    if ({current_state, wr_addr} !== {3'd3, 6'd4}) begin
      bad++; $display("FAIL rst_mid_pre: got %h want %h", {current_state, wr_addr}, {3'd3, 6'd4});
    end
    rst = 1'b1; tick; rst = 1'b0;
    total++;
    if ({current_state, tx_start, mult_start, wr_en_a, wr_en_b, error, rx_enable} !==
        {3'd0, 6'b000001}) begin
      bad++; $display("FAIL rst_mid_flags: got %b want 000000001",
                      {current_state, tx_start, mult_start, wr_en_a, wr_en_b, error, rx_enable});
    end
    total++;
    if ({dim_m, dim_k, dim_p, wr_addr, res_addr, res_byte_sel} !== 25'd0) begin
      bad++; $display("FAIL rst_mid_regs: got %h want 0",
                      {dim_m, dim_k, dim_p, wr_addr, res_addr, res_byte_sel});
    end
    send(8'hA5); send(8'h11); send(8'h01);
    feed(1); feed(1);
    total++;
    if ({current_state, mult_start} !== {3'd5, 1'b1}) begin
      bad++; $display("FAIL rst_mid_compute: got %b want 1011", {current_state, mult_start});
    end
    mult_done = 1'b1; tick; mult_done = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30 && current_state != 3'd0; c++) begin
      if (tx_start) pulses++;
      tick;
    end
    total++;
    if (pulses != 2 || current_state !== 3'd0) begin
      bad++; $display("FAIL rst_mid_frame: got %0d pulses state %0d want 2 pulses state 0",
                      pulses, current_state);
    end
  endtask

  task automatic test_timeout;
    int stray;
    do_reset;
    send(8'hA5); send(8'h11); send(8'h01);
    feed(1); feed(1);
    stray = 0;
`ifdef MATMUL_CTRL_TIMEOUT_EN
    for (int c = 0; c < 99; c++) begin
      if (current_state != 3'd5) stray++;
      tick;
    end
    total++;
    if (stray != 0 || current_state !== 3'd5) begin
      bad++; $display("FAIL timeout_wait: got %0d stray state %0d want 0 stray state 5", stray,
                      current_state);
    end
    tick;
    total++;
    if ({current_state, error} !== {3'd7, 1'b1}) begin
      bad++; $display("FAIL timeout_err: got %b want 1111", {current_state, error});
    end
`else
    for (int c = 0; c < 1000; c++) begin
      if (current_state != 3'd5) stray++;
      tick;
    end
    total++;
    if (stray != 0 || current_state !== 3'd5 || error !== 1'b0) begin
      bad++; $display("FAIL timeout_none: got %0d stray state %0d error %b want 0 5 0", stray,
                      current_state, error);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_load;
    test_send;
    test_error;
    test_busy;
    test_rst_midload;
    test_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
